// File: rtl/core_pkg.sv
// Shared core definitions: canonical NOP, RV32I major opcodes and the hazard FSM states.
package core_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  localparam logic [6:0] OP_LOAD   = 7'b000_0011;
  localparam logic [6:0] OP_STORE  = 7'b010_0011;
  localparam logic [6:0] OP_BRANCH = 7'b110_0011;
  localparam logic [6:0] OP_JAL    = 7'b110_1111;
  localparam logic [6:0] OP_JALR   = 7'b110_0111;
  localparam logic [6:0] OP_IMM    = 7'b001_0011;
  localparam logic [6:0] OP_LUI    = 7'b011_0111;
  localparam logic [6:0] OP_AUIPC  = 7'b001_0111;

  typedef enum logic [0:0] {
    StRun,
    StMemWait
  } hz_state_e;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous active-low reset; holds at all-ones.
module sat_counter #(
  parameter int unsigned W = 32
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         inc_i,
  output logic [W-1:0] count_o
);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (inc_i && (count_q != '1)) begin
      count_d = count_q + W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// 5-stage pipeline sequencer: per-register advance/hold/flush from memory waits,
// EX redirects and load-use hazards, plus stall/flush performance counters.
module pipe_hazard_ctrl
  import core_pkg::*;
#(
  parameter int unsigned CNT_W    = 32,
  parameter int unsigned WAIT_MAX = 255
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [4:0]       id_rs1_i,
  input  logic [4:0]       id_rs2_i,
  input  logic             id_use_rs1_i,
  input  logic             id_use_rs2_i,
  input  logic [4:0]       ex_rd_i,
  input  logic             ex_mem_read_i,
  input  logic             ex_redirect_i,
  input  logic             dmem_req_i,
  input  logic             dmem_ready_i,
  output logic             pc_en_o,
  output logic             pc_sel_redirect_o,
  output logic             if_id_en_o,
  output logic             if_id_flush_o,
  output logic             id_ex_en_o,
  output logic             id_ex_flush_o,
  output logic             ex_mem_en_o,
  output logic             mem_wb_en_o,
  output logic             mem_wb_bubble_o,
  output logic             dmem_timeout_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
);

  localparam logic [15:0] WaitMax = 16'(WAIT_MAX);

  hz_state_e   state_q, state_d;
  logic [15:0] wait_cnt_q, wait_cnt_d;
  logic        timeout_q, timeout_d;
  logic        mem_hold, load_use;

  assign mem_hold = dmem_req_i & ~dmem_ready_i;
  assign load_use = ex_mem_read_i && (ex_rd_i != 5'd0) &&
                    ((id_use_rs1_i && (id_rs1_i == ex_rd_i)) ||
                     (id_use_rs2_i && (id_rs2_i == ex_rd_i)));

  always_comb begin
    pc_en_o           = 1'b1;
    pc_sel_redirect_o = 1'b0;
    if_id_en_o        = 1'b1;
    if_id_flush_o     = 1'b0;
    id_ex_en_o        = 1'b1;
    id_ex_flush_o     = 1'b0;
    ex_mem_en_o       = 1'b1;
    mem_wb_en_o       = 1'b1;
    mem_wb_bubble_o   = 1'b0;
    if (!rst_ni) begin
      pc_en_o         = 1'b0;
      if_id_en_o      = 1'b0;
      id_ex_en_o      = 1'b0;
      ex_mem_en_o     = 1'b0;
      mem_wb_en_o     = 1'b0;
      if_id_flush_o   = 1'b1;
      id_ex_flush_o   = 1'b1;
      mem_wb_bubble_o = 1'b1;
    end else if (mem_hold) begin
      // Redirect/load-use inputs are frozen in place, so they re-present after the wait.
      pc_en_o         = 1'b0;
      if_id_en_o      = 1'b0;
      id_ex_en_o      = 1'b0;
      ex_mem_en_o     = 1'b0;
      mem_wb_bubble_o = 1'b1;
    end else if (ex_redirect_i) begin
      pc_sel_redirect_o = 1'b1;
      if_id_flush_o     = 1'b1;
      id_ex_flush_o     = 1'b1;
    end else if (load_use) begin
      pc_en_o       = 1'b0;
      if_id_en_o    = 1'b0;
      id_ex_flush_o = 1'b1;
    end
  end

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    timeout_d  = timeout_q;
    unique case (state_q)
      StRun: begin
        if (mem_hold) begin
          state_d    = StMemWait;
          wait_cnt_d = 16'd1;
        end
      end
      StMemWait: begin
        if (mem_hold) begin
          if (wait_cnt_q == WaitMax) begin
            timeout_d = 1'b1;
          end else begin
            wait_cnt_d = wait_cnt_q + 16'd1;
          end
        end else begin
          state_d    = StRun;
          wait_cnt_d = '0;
        end
      end
      default: begin
        state_d    = StRun;
        wait_cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q    <= StRun;
      wait_cnt_q <= '0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      timeout_q  <= timeout_d;
    end
  end

  assign dmem_timeout_o = timeout_q;

  sat_counter #(
    .W (CNT_W)
  ) u_stall_cnt (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .inc_i   (~pc_en_o),
    .count_o (stall_cnt_o)
  );

  sat_counter #(
    .W (CNT_W)
  ) u_flush_cnt (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .inc_i   (if_id_flush_o),
    .count_o (flush_cnt_o)
  );

endmodule
